// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
//   Shared types for the I2C command sequencer.
//   - seq_state_t : sequencer FSM state encoding (plain constants so the
//                   encoding stays fixed and readable in legacy waveforms).
//   - i2c_cmd_t   : one queued single-byte command {addr, rw, data}.
//   - pack_cmd    : builds an i2c_cmd_t from its separate fields.
// ---------------------------------------------------------------------------
package i2c_pkg;

    typedef logic [2:0] seq_state_t;

    localparam seq_state_t ST_IDLE    = 3'd0;
    localparam seq_state_t ST_ISSUE   = 3'd1;
    localparam seq_state_t ST_XFER    = 3'd2;
    localparam seq_state_t ST_CAPTURE = 3'd3;
    localparam seq_state_t ST_GAP     = 3'd4;

    typedef struct packed {
        logic [6:0] addr;
        logic       rw;     // 0 = write, 1 = read
        logic [7:0] data;   // write byte; don't-care for reads
    } i2c_cmd_t;

    function automatic i2c_cmd_t pack_cmd(input logic [6:0] addr,
                                          input logic       rw,
                                          input logic [7:0] data);
        i2c_cmd_t c;
        c.addr = addr;
        c.rw   = rw;
        c.data = data;
        return c;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
//   Single-clock first-word-fall-through FIFO. The head entry is visible on
//   rd_data_o whenever empty_o is low; asserting rd_en_i consumes it.
//   Ports:
//     clk, rst    : clock, synchronous active-high reset (flushes the FIFO)
//     wr_en_i     : push request, ignored while full_o is high
//     wr_data_i   : data to push
//     full_o      : registered-count full flag (use as !ready upstream)
//     rd_en_i     : pop request, ignored while empty_o is high
//     rd_data_o   : current head entry
//     empty_o     : no entry available
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4     // power of 2, >= 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic             full_o,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             empty_o
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push;
    logic             pop;

    assign full_o    = (count_q == FULL_CNT);
    assign empty_o   = (count_q == '0);
    assign push      = wr_en_i && !full_o;
    assign pop       = rd_en_i && !empty_o;
    assign rd_data_o = mem_q[rd_ptr_q];

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // Pointers are exactly AW bits, so they wrap modulo DEPTH for free.
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the count/pointers define
    // validity, and leaving the array reset-free lets it map onto RAM.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// i2c_cmd_sequencer
//   Front-end for an I2C byte driver. Commands are queued, issued one at a
//   time with a start/busy handshake, read bytes are returned through a
//   response FIFO, and a driver that never acknowledges start is reported as
//   a timeout.
//   Ports:
//     clk, rst                 : clock, synchronous active-high reset
//     cmd_valid/cmd_ready      : command handshake (cmd_ready = queue not full)
//     cmd_addr/cmd_rw/cmd_data : command fields (cmd_data ignored for reads)
//     rsp_valid/rsp_ready      : read-byte handshake, rsp_data = byte
//     drv_start/rw/addr/data   : registered outputs to the byte driver
//     drv_busy/drv_rdata       : status and read byte from the driver
//     err_timeout              : 1-cycle pulse when a command is dropped
//     seq_active               : FSM is not IDLE
// ---------------------------------------------------------------------------
module i2c_cmd_sequencer
    import i2c_pkg::*;
#(
    parameter int CMD_DEPTH   = 4,
    parameter int RSP_DEPTH   = 4,
    parameter int GAP_CYCLES  = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic       cmd_rw,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       drv_start,
    output logic       drv_rw,
    output logic [6:0] drv_addr,
    output logic [7:0] drv_data,
    input  logic       drv_busy,
    input  logic [7:0] drv_rdata,
    output logic       err_timeout,
    output logic       seq_active
);

    localparam int            TW       = $clog2(TIMEOUT_CYC) + 1;
    localparam int            GW       = $clog2(GAP_CYCLES) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    seq_state_t    state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          drv_start_q;
    logic [6:0]    drv_addr_q;
    logic          drv_rw_q;
    logic [7:0]    drv_data_q;
    logic          err_q;

    i2c_cmd_t      cmd_in;
    i2c_cmd_t      cmd_head;
    logic          cmd_full;
    logic          cmd_empty;
    logic          cmd_push;
    logic          dispatch;
    logic          rsp_full;
    logic          rsp_empty;
    logic          rsp_push;
    logic          tmo_fire;

    // ---------------- command queue ----------------
    // Ready is held low during reset so nothing is accepted while flushing.
    assign cmd_ready = !rst && !cmd_full;
    assign cmd_push  = cmd_valid && cmd_ready;
    assign cmd_in    = pack_cmd(cmd_addr, cmd_rw, cmd_data);

    sync_fifo #(
        .WIDTH ($bits(i2c_cmd_t)),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (cmd_push),
        .wr_data_i (cmd_in),
        .full_o    (cmd_full),
        .rd_en_i   (dispatch),
        .rd_data_o (cmd_head),
        .empty_o   (cmd_empty)
    );

    // ---------------- response queue ----------------
    assign rsp_valid = !rsp_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (rsp_push),
        .wr_data_i (drv_rdata),
        .full_o    (rsp_full),
        .rd_en_i   (rsp_ready),
        .rd_data_o (rsp_data),
        .empty_o   (rsp_empty)
    );

    // ---------------- sequencing FSM ----------------
    // NOTE: every signal written here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        tmo_d    = tmo_q;
        gap_d    = gap_q;
        dispatch = 1'b0;
        rsp_push = 1'b0;
        tmo_fire = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A read only leaves the queue once its response slot is
                // free, which is what lets CAPTURE push unconditionally.
                if (!cmd_empty && (!cmd_head.rw || !rsp_full)) begin
                    dispatch = 1'b1;
                    tmo_d    = '0;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Busy wins over the timeout, and a busy already high on
                // entry counts as acknowledgement.
                if (drv_busy) begin
                    tmo_d   = '0;
                    state_d = ST_XFER;
                end else if (tmo_q == TMO_LAST) begin
                    tmo_fire = 1'b1;
                    tmo_d    = '0;
                    gap_d    = '0;
                    state_d  = ST_GAP;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_XFER: begin
                if (!drv_busy) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                rsp_push = drv_rw_q;
                gap_d    = '0;
                state_d  = ST_GAP;
            end
            ST_GAP: begin
                // Keeps drv_start low long enough that the next command
                // presents a clean rising edge to the driver.
                if (gap_q == GAP_LAST) state_d = ST_IDLE;
                else                   gap_d   = gap_q + GW'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tmo_q       <= '0;
            gap_q       <= '0;
            drv_start_q <= 1'b0;
            drv_addr_q  <= '0;
            drv_rw_q    <= 1'b0;
            drv_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            gap_q       <= gap_d;
            // Registered from the next state: glitch-free and exactly
            // coincident with the ISSUE state.
            drv_start_q <= (state_d == ST_ISSUE);
            err_q       <= tmo_fire;
            // The driver samples rw/data late, so these only change on a
            // new dispatch and hold through XFER, CAPTURE and GAP.
            if (dispatch) begin
                drv_addr_q <= cmd_head.addr;
                drv_rw_q   <= cmd_head.rw;
                drv_data_q <= cmd_head.data;
            end
        end
    end

    assign drv_start   = drv_start_q;
    assign drv_addr    = drv_addr_q;
    assign drv_rw      = drv_rw_q;
    assign drv_data    = drv_data_q;
    assign err_timeout = err_q;
    assign seq_active  = (state_q != ST_IDLE);

    // Read dispatch reserves a response slot, so CAPTURE never overflows.
    assert property (@(posedge clk) disable iff (rst) rsp_push |-> !rsp_full);

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_i2c_cmd_sequencer
//   Directed bench for i2c_cmd_sequencer with a simple behavioural byte
//   driver: busy rises mdl_dly cycles after start, holds mdl_hold cycles,
//   and each read returns rd_base + (reads so far).
// ---------------------------------------------------------------------------
module tb_i2c_cmd_sequencer;
    import i2c_pkg::*;

    localparam int GAP = 4;
    localparam int TMO = 1024;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [6:0] cmd_addr = '0;
    logic       cmd_rw = 1'b0;
    logic [7:0] cmd_data = '0;
    logic       rsp_ready = 1'b0;
    logic       drv_busy = 1'b0;
    logic [7:0] drv_rdata = '0;

    logic       cmd_ready;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       drv_start;
    logic       drv_rw;
    logic [6:0] drv_addr;
    logic [7:0] drv_data;
    logic       err_timeout;
    logic       seq_active;

    i2c_cmd_sequencer #(
        .CMD_DEPTH   (4),
        .RSP_DEPTH   (4),
        .GAP_CYCLES  (GAP),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_rw      (cmd_rw),
        .cmd_data    (cmd_data),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .drv_start   (drv_start),
        .drv_rw      (drv_rw),
        .drv_addr    (drv_addr),
        .drv_data    (drv_data),
        .drv_busy    (drv_busy),
        .drv_rdata   (drv_rdata),
        .err_timeout (err_timeout),
        .seq_active  (seq_active)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver model (acts on negedge) ----------------
    bit         mdl_en   = 1'b1;
    int         mdl_dly  = 3;
    int         mdl_hold = 40;
    logic [7:0] rd_base  = '0;
    logic [7:0] rd_seq   = '0;
    int         fall_cyc = 0;

    initial begin
        int ph  = 0;
        int cnt = 0;
        forever begin
            @(negedge clk);
            if (rst || !mdl_en) begin
                drv_busy = 1'b0;
                ph  = 0;
                cnt = 0;
            end else begin
                case (ph)
                    0: if (drv_start) begin
                        cnt++;
                        if (cnt >= mdl_dly) begin
                            drv_busy  = 1'b1;
                            drv_rdata = rd_base + rd_seq;
                            if (drv_rw) rd_seq++;
                            ph  = 1;
                            cnt = 0;
                        end
                    end
                    1: begin
                        cnt++;
                        if (cnt >= mdl_hold) begin
                            drv_busy = 1'b0;
                            fall_cyc = cyc;
                            ph = 2;
                        end
                    end
                    default: if (!drv_start) ph = 0;
                endcase
            end
        end
    end

    // ---------------- monitor (samples 2 ns after posedge) ----------------
    i2c_cmd_t issued[$];
    i2c_cmd_t snap = '0;
    logic     prev_start = 1'b0;
    logic     prev_rv = 1'b0;
    int       issue_cyc = 0;
    int       high_run = 0;
    int       last_high = 0;
    int       low_run = 0;
    int       min_low = 1000000;
    int       err_cnt = 0;
    int       err_cyc = 0;
    int       rv_rise_cyc = 0;
    int       stab_err = 0;

    initial forever begin
        @(posedge clk);
        #2;
        if (drv_start && !prev_start) begin
            if (low_run < min_low) min_low = low_run;
            low_run   = 0;
            high_run  = 0;
            issue_cyc = cyc;
            snap      = {drv_addr, drv_rw, drv_data};
            issued.push_back(snap);
        end
        if (drv_start) high_run++;
        else begin
            if (prev_start) last_high = high_run;
            low_run++;
        end
        if (seq_active && ({drv_addr, drv_rw, drv_data} != snap)) stab_err++;
        if (err_timeout) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (rsp_valid && !prev_rv) rv_rise_cyc = cyc;
        prev_start = drv_start;
        prev_rv    = rsp_valid;
    end

    // ---------------- stimulus helpers (called at negedge) ----------------
    int acc_cyc = 0;
    int pop_cyc = 0;

    task automatic push_cmd(input logic [6:0] a, input logic rw, input logic [7:0] d);
        int n = 0;
        cmd_addr  = a;
        cmd_rw    = rw;
        cmd_data  = d;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        acc_cyc = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("push_wait", n < 2000, 1);
    endtask

    task automatic pop_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        pop_cyc = cyc;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int zeros = 0;
        int n = 0;
        while (zeros < 3 && n < budget) begin
            @(negedge clk);
            n++;
            zeros = seq_active ? 0 : zeros + 1;
        end
        check({tag, "_idle"}, zeros, 3);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        int t_acc;
        int t_iss;
        int t_err;
        int n;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_drv_start", drv_start, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_seq_active", seq_active, 0);
        check("rst_err", err_timeout, 0);
        check("rst_drv_fields", {drv_addr, drv_rw, drv_data}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready_after", cmd_ready, 1);

        // 1: single write
        mdl_dly = 3; mdl_hold = 40;
        issued.delete();
        push_cmd(7'h50, 1'b0, 8'hA5);
        t_acc = acc_cyc;
        wait_idle("t1", 300);
        check("t1_latency", issue_cyc - t_acc, 2);
        check("t1_issued_n", issued.size(), 1);
        check("t1_cmd", issued[0], {7'h50, 1'b0, 8'hA5});
        check("t1_start_len", last_high, 3);
        check("t1_no_rsp", rsp_valid, 0);
        check("t1_seq_active", seq_active, 0);

        // 2: single read, response held until ready
        mdl_hold = 10; rd_base = 8'h3C; rd_seq = '0;
        issued.delete();
        push_cmd(7'h68, 1'b1, 8'h00);
        wait_idle("t2", 300);
        check("t2_cmd", issued[0], {7'h68, 1'b1, 8'h00});
        check("t2_rsp_lat", rv_rise_cyc - fall_cyc, 2);
        repeat (5) @(negedge clk);
        check("t2_rsp_hold", rsp_valid, 1);
        check("t2_rsp_data", rsp_data, 8'h3C);
        pop_rsp();
        check("t2_rsp_popped", rsp_valid, 0);

        // 3: one command in flight, then W,R,W,R fill the queue
        mdl_hold = 40; rd_base = 8'hC3; rd_seq = '0; min_low = 1000000;
        issued.delete();
        push_cmd(7'h11, 1'b0, 8'h01);
        push_cmd(7'h21, 1'b0, 8'h22);
        push_cmd(7'h23, 1'b1, 8'h00);
        push_cmd(7'h24, 1'b0, 8'h44);
        push_cmd(7'h25, 1'b1, 8'h00);
        check("t3_full", cmd_ready, 0);
        wait_idle("t3", 1000);
        check("t3_issued_n", issued.size(), 5);
        check("t3_cmd1", issued[1], {7'h21, 1'b0, 8'h22});
        check("t3_cmd2", issued[2], {7'h23, 1'b1, 8'h00});
        check("t3_cmd3", issued[3], {7'h24, 1'b0, 8'h44});
        check("t3_cmd4", issued[4], {7'h25, 1'b1, 8'h00});
        check("t3_gap_min", min_low >= GAP, 1);
        check("t3_rsp0", rsp_data, 8'hC3);
        pop_rsp();
        check("t3_rsp1", rsp_data, 8'hC4);
        pop_rsp();
        check("t3_rsp_empty", rsp_valid, 0);

        // 4: driver never acknowledges; second command follows the gap
        mdl_en = 1'b0;
        issued.delete();
        push_cmd(7'h30, 1'b0, 8'h77);
        push_cmd(7'h31, 1'b0, 8'h78);
        n = 0;
        while (err_cnt == 0 && n < TMO + 200) begin
            @(negedge clk);
            n++;
        end
        t_iss = issue_cyc;
        t_err = err_cyc;
        check("t4_err_seen", err_cnt, 1);
        check("t4_tmo_lat", t_err - t_iss, TMO);
        check("t4_start_len", last_high, TMO);
        mdl_en = 1'b1;
        wait_idle("t4", 400);
        check("t4_next_issue", issue_cyc - t_err, GAP + 1);
        check("t4_issued_n", issued.size(), 2);
        check("t4_cmd1", issued[1], {7'h31, 1'b0, 8'h78});
        check("t4_err_once", err_cnt, 1);
        check("t4_no_rsp", rsp_valid, 0);

        // 5: five reads against a 4-deep response queue
        mdl_hold = 5; rd_base = 8'h90; rd_seq = '0;
        issued.delete();
        for (int i = 0; i < 5; i++) push_cmd(7'h40 + 7'(i), 1'b1, 8'h00);
        wait_idle("t5a", 600);
        repeat (10) @(negedge clk);
        check("t5_held_n", issued.size(), 4);
        check("t5_held_idle", seq_active, 0);
        check("t5_rsp0", rsp_data, 8'h90);
        pop_rsp();
        wait_idle("t5b", 200);
        check("t5_issued_n", issued.size(), 5);
        check("t5_pop_to_issue", issue_cyc - pop_cyc, 1);
        check("t5_cmd4", issued[4], {7'h44, 1'b1, 8'h00});
        for (int i = 1; i < 4; i++) begin
            check($sformatf("t5_rsp%0d", i), rsp_data, 8'h90 + 8'(i));
            pop_rsp();
        end
        check("t5_rsp4", rsp_data, 8'h94);

        // 6: reset while the driver is mid-transfer
        mdl_hold = 40;
        issued.delete();
        push_cmd(7'h5A, 1'b0, 8'h11);
        n = 0;
        while (!(seq_active && !drv_start && issued.size() == 1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check("t6_in_xfer", seq_active && !drv_start, 1);
        check("t6_rsp_pending", rsp_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        check("t6_seq_active", seq_active, 0);
        check("t6_drv_start", drv_start, 0);
        check("t6_rsp_valid", rsp_valid, 0);
        check("t6_cmd_ready", cmd_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t6_ready_after", cmd_ready, 1);
        check("t6_no_err", err_cnt, 1);
        repeat (5) @(negedge clk);
        issued.delete();
        push_cmd(7'h5B, 1'b0, 8'h22);
        wait_idle("t6", 300);
        check("t6_cmd", issued[0], {7'h5B, 1'b0, 8'h22});
        check("t6_rsp_none", rsp_valid, 0);

        check("drv_fields_stable", stab_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
